firebird7_in_gate1_tessent_data_mux_sync: RTL
=============================================

// Module: firebird7_in_gate1_tessent_data_mux_sync
//
// PURPOSE
// - Multi-channel IJTAG data-override mux; the generalised successor of the fixed 3-bit combinational data mux.
// - Each of CHANNELS lanes of WIDTH bits either passes functional data or drives an IJTAG-loaded shadow value.
// - Select changes are sequenced per lane with a registered hold window, so the output never mixes sources mid-cycle.
// - Sits between the IJTAG SIB/TDR network and the functional logic it overrides.
//
// PARAMETERS
// - WIDTH        3   bits per channel (>=1)
// - CHANNELS     6   number of independent lanes (>=1)
// - HOLD_CYCLES  2   cycles a lane freezes its last output on each source switch (0 = switch on next edge)
// - RESET_VALUE  '0  WIDTH-bit reset value of every shadow register
//
// PORTS
// - ijtag_tck           in   1               clock; all state on posedge
// - ijtag_reset         in   1               asynchronous, active-high reset
// - ijtag_sel           in   CHANNELS        requested source per lane (1 = IJTAG, 0 = functional)
// - ijtag_update_en     in   1               load all shadow registers from ijtag_data_in
// - ijtag_data_in       in   CHANNELS*WIDTH  IJTAG override data; lane c = [c*WIDTH +: WIDTH]
// - functional_data_in  in   CHANNELS*WIDTH  functional data; same lane packing
// - data_out            out  CHANNELS*WIDTH  muxed output; same lane packing
// - active_sel          out  CHANNELS        1 = lane currently drives its shadow value
// - switch_busy         out  CHANNELS        1 = lane is in a hold window
//
// BEHAVIOUR
// - Reset (async assert, sync-to-clock release): all lanes FUNC, shadows = RESET_VALUE, hold regs = 0,
//   counters = 0; active_sel = 0, switch_busy = 0, data_out = functional_data_in (combinational).
// - Per-lane FSM: FUNC, HOLD_TO_IJ, IJTAG, HOLD_TO_FUNC.
// - FUNC: data_out lane = functional_data_in lane (0-cycle path). On an edge with ijtag_sel[c]=1:
//   hold <= current functional lane value, cnt <= HOLD_CYCLES-1, go HOLD_TO_IJ (IJTAG directly if HOLD_CYCLES=0).
// - HOLD_TO_IJ / HOLD_TO_FUNC: data_out lane = hold; switch_busy[c]=1; cnt decrements each edge;
//   at cnt==0 go IJTAG / FUNC respectively. Lane stays in hold exactly HOLD_CYCLES cycles.
// - IJTAG: data_out lane = shadow[c]; active_sel[c]=1. On an edge with ijtag_sel[c]=0:
//   hold <= shadow[c], cnt <= HOLD_CYCLES-1, go HOLD_TO_FUNC (FUNC directly if HOLD_CYCLES=0).
// - ijtag_sel changes during a hold are ignored; no abort. Sel is re-evaluated in the destination state,
//   so a request reversed mid-hold produces a second full hold window in the opposite direction.
// - Shadow: at an edge with ijtag_update_en=1, every shadow[c] <= ijtag_data_in lane, independent of state;
//   the new value is visible on data_out the cycle after the edge (IJTAG state) or after the hold completes.
// - Update during HOLD_TO_FUNC does not change the frozen hold value.
// - active_sel and switch_busy are registered state decodes; never both 1 on one lane.
// - Lanes are fully independent; simultaneous switches on several lanes carry no cross-lane ordering.
// - Reset mid-hold or in IJTAG: lane returns to FUNC immediately (async); output reverts to functional data.
// - Counter width = $clog2(HOLD_CYCLES+1), min 1; no wrap is reachable.
//
// STRUCTURE
// - Package firebird7_in_gate1_tessent_data_mux_sync_pkg: lane_state_e enum (FUNC, HOLD_TO_IJ, IJTAG,
//   HOLD_TO_FUNC) and a cnt_width(hold) constant function.
// - One sub-module: firebird7_in_gate1_tessent_data_mux_sync_lane (one lane: FSM, counter, hold, shadow,
//   output mux), instantiated CHANNELS times in a generate loop; top level only does lane slicing.
//
// TESTING (WIDTH=3, CHANNELS=6, HOLD_CYCLES=2 unless stated)
// - Reset, ijtag_sel=0, functional lanes=0..5 -> data_out = functional bit-for-bit same cycle; active_sel=0, busy=0.
// - Shadow lane0=3'b010, sel[0]=1 at edge 10, functional lane0=3'b101 then 3'b000 at cycle 11 ->
//   data_out lane0=101 cycles 11-12, busy[0]=1; 010 from cycle 13, active_sel[0]=1; other lanes unaffected.
// - In IJTAG, update_en with lane0=3'b111 -> lane0 output 111 next cycle; sel[0]=0 -> holds 111 two cycles, then functional.
// - sel[0] pulsed 1 for one cycle -> full HOLD_TO_IJ, one IJTAG cycle, then full HOLD_TO_FUNC; no glitch to other values.
// - ijtag_reset asserted mid HOLD_TO_IJ -> same-cycle functional output, busy=0, shadow back to RESET_VALUE.
// - HOLD_CYCLES=0 build: sel[3]=1 at edge N -> shadow on lane3 from cycle N+1, switch_busy never asserts.

Source files
------------

// File: rtl/firebird7_in_gate1_tessent_data_mux_sync_pkg.sv
// rtl/firebird7_in_gate1_tessent_data_mux_sync_pkg.sv - shared lane state type and counter sizing helper
package firebird7_in_gate1_tessent_data_mux_sync_pkg;

  // Per-lane source state: functional, freezing towards IJTAG, IJTAG, freezing towards functional.
  typedef enum logic [1:0] {
    FUNC         = 2'd0,
    HOLD_TO_IJ   = 2'd1,
    IJTAG        = 2'd2,
    HOLD_TO_FUNC = 2'd3
  } lane_state_e;

  // Hold counter width: enough to hold HOLD_CYCLES-1, never narrower than one bit.
  function automatic int cnt_width(input int hold);
    return (hold < 1) ? 1 : $clog2(hold + 1);
  endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_data_mux_sync_lane.sv
// rtl/firebird7_in_gate1_tessent_data_mux_sync_lane.sv - one override lane: FSM, hold counter, hold and shadow registers, output mux
module firebird7_in_gate1_tessent_data_mux_sync_lane
  import firebird7_in_gate1_tessent_data_mux_sync_pkg::*;
#(
  parameter int               WIDTH       = 3,
  parameter int               HOLD_CYCLES = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             ijtag_sel,
  input  logic             ijtag_update_en,
  input  logic [WIDTH-1:0] ijtag_data_in,
  input  logic [WIDTH-1:0] functional_data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             active_sel,
  output logic             switch_busy
);

  localparam int CW = cnt_width(HOLD_CYCLES);
  // Value loaded on entry to a hold so that the lane stays frozen exactly HOLD_CYCLES cycles.
  localparam logic [CW-1:0] CNT_LOAD = (HOLD_CYCLES > 0) ? CW'(HOLD_CYCLES - 1) : '0;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam bit            NO_HOLD  = (HOLD_CYCLES == 0);

  lane_state_e      r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hold;
  logic [WIDTH-1:0] r_shadow;

  lane_state_e      w_state_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] w_hold_nxt;

  // State, counter and frozen-value registers; reset returns the lane to functional at once.
  always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
    if (ijtag_reset) begin
      r_state <= FUNC;
      r_cnt   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  // Shadow loads on every update pulse regardless of lane state; a running hold keeps its own copy.
  always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
    if (ijtag_reset) begin
      r_shadow <= RESET_VALUE;
    end else if (ijtag_update_en) begin
      r_shadow <= ijtag_data_in;
    end
  end

  // Next-state logic: select is only sampled in FUNC/IJTAG, holds always run to completion.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hold_nxt  = r_hold;
    case (r_state)
      FUNC: begin
        if (ijtag_sel) begin
          w_hold_nxt  = functional_data_in;
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = NO_HOLD ? IJTAG : HOLD_TO_IJ;
        end
      end
      HOLD_TO_IJ: begin
        if (r_cnt == '0) begin
          w_state_nxt = IJTAG;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      IJTAG: begin
        if (!ijtag_sel) begin
          w_hold_nxt  = r_shadow;
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = NO_HOLD ? FUNC : HOLD_TO_FUNC;
        end
      end
      HOLD_TO_FUNC: begin
        if (r_cnt == '0) begin
          w_state_nxt = FUNC;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = FUNC;
      end
    endcase
  end

  // Output mux and status decodes of the registered state; functional data is a zero-cycle path.
  always_comb begin
    data_out    = functional_data_in;
    active_sel  = 1'b0;
    switch_busy = 1'b0;
    case (r_state)
      HOLD_TO_IJ, HOLD_TO_FUNC: begin
        data_out    = r_hold;
        switch_busy = 1'b1;
      end
      IJTAG: begin
        data_out   = r_shadow;
        active_sel = 1'b1;
      end
      default: begin
        data_out = functional_data_in;
      end
    endcase
  end

endmodule

// File: rtl/firebird7_in_gate1_tessent_data_mux_sync.sv
// rtl/firebird7_in_gate1_tessent_data_mux_sync.sv - multi-lane IJTAG data-override mux with sequenced source switching
module firebird7_in_gate1_tessent_data_mux_sync
  import firebird7_in_gate1_tessent_data_mux_sync_pkg::*;
#(
  parameter int               WIDTH       = 3,
  parameter int               CHANNELS    = 6,
  parameter int               HOLD_CYCLES = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                      ijtag_tck,
  input  logic                      ijtag_reset,
  input  logic [CHANNELS-1:0]       ijtag_sel,
  input  logic                      ijtag_update_en,
  input  logic [CHANNELS*WIDTH-1:0] ijtag_data_in,
  input  logic [CHANNELS*WIDTH-1:0] functional_data_in,
  output logic [CHANNELS*WIDTH-1:0] data_out,
  output logic [CHANNELS-1:0]       active_sel,
  output logic [CHANNELS-1:0]       switch_busy
);

  // Lanes are independent; the top only slices the packed buses.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    firebird7_in_gate1_tessent_data_mux_sync_lane #(
      .WIDTH       (WIDTH),
      .HOLD_CYCLES (HOLD_CYCLES),
      .RESET_VALUE (RESET_VALUE)
    ) u_lane (
      .ijtag_tck          (ijtag_tck),
      .ijtag_reset        (ijtag_reset),
      .ijtag_sel          (ijtag_sel[c]),
      .ijtag_update_en    (ijtag_update_en),
      .ijtag_data_in      (ijtag_data_in[c*WIDTH +: WIDTH]),
      .functional_data_in (functional_data_in[c*WIDTH +: WIDTH]),
      .data_out           (data_out[c*WIDTH +: WIDTH]),
      .active_sel         (active_sel[c]),
      .switch_busy        (switch_busy[c])
    );
  end

endmodule
